// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame-format types and defaults
package uart_pkg;
    typedef enum logic [0:0] {STOP_BITS_1, STOP_BITS_2} stop_bits_t;
    typedef enum logic [1:0] {PARITY_NONE, PARITY_EVEN, PARITY_ODD} parity_t;
    localparam int UART_OVERSAMPLE_DEFAULT = 16;
endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop synchronizer for an asynchronous input, resets to 1
module uart_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [1:0] ff_q, ff_d;
    always_comb ff_d = {ff_q[0], d};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ff_q <= 2'b11;
        else        ff_q <= ff_d;
    assign q = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver; UART_RX_MAJORITY_EN selects 2-of-3 mid-bit voting
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_wren,
    input  logic       rx_full,
    output logic       rx_busy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    input  logic [3:0] num_data_bits,
    input  stop_bits_t stop_bits,
    input  parity_t    parity
);
    localparam int TW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC = OVERSAMPLE / 2;
`else
    localparam int DEC = OVERSAMPLE / 2 - 1;
`endif
    localparam logic [TW-1:0] DEC_T  = TW'(DEC);
    localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;

    logic          rx_s, bit_v;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d, last_q, last_d;
    logic [7:0]    data_q, data_d, rx_data_q, rx_data_d;
    logic          armed_q, armed_d, stop2_q, stop2_d;
    parity_t       par_q, par_d;
    logic          par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic          rx_wren_q, rx_wren_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic          done;

    uart_sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));

`ifdef UART_RX_MAJORITY_EN
    // the two samples preceding the decision tick, shifted on every tick
    logic [1:0] smp_q, smp_d;
    always_comb smp_d = sample_tick ? {smp_q[0], rx_s} : smp_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) smp_q <= 2'b11;
        else        smp_q <= smp_d;
    assign bit_v = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s) | (smp_q[0] & rx_s);
`else
    assign bit_v = rx_s;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        data_d    = data_q;
        rx_data_d = rx_data_q;
        armed_d   = armed_q;
        stop2_d   = stop2_q;
        par_d     = par_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        rx_wren_d = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        done      = 1'b0;
        if (sample_tick) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (rx_s) armed_d = 1'b1;
                    else if (armed_q) begin
                        state_d   = S_START;
                        bit_cnt_d = '0;
                        data_d    = '0;
                        par_err_d = 1'b0;
                        frm_err_d = 1'b0;
                        last_d    = (num_data_bits >= 4'd5 && num_data_bits <= 4'd8) ?
                                    3'(num_data_bits - 4'd1) : 3'd7;
                        stop2_d   = stop_bits == STOP_BITS_2;
                        par_d     = parity;
                    end
                end
                S_START: begin
                    if (cnt_q == DEC_T && bit_v) state_d = S_IDLE;
                    else if (cnt_q == LAST_T) state_d = S_DATA;
                end
                S_DATA: begin
                    if (cnt_q == DEC_T) data_d[bit_cnt_q] = bit_v;
                    if (cnt_q == LAST_T) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == last_q) state_d = (par_q != PARITY_NONE) ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == DEC_T) par_err_d = bit_v != ((par_q == PARITY_ODD) ? ~^data_q : ^data_q);
                    if (cnt_q == LAST_T) state_d = S_STOP1;
                end
                S_STOP1: begin
                    if (cnt_q == DEC_T) begin
                        frm_err_d = ~bit_v;
                        done      = ~stop2_q;
                    end
                    if (cnt_q == LAST_T) state_d = S_STOP2;
                end
                S_STOP2: done = cnt_q == DEC_T;
                default: state_d = S_IDLE;
            endcase
            // finish at mid-stop and require the line to return high before the next start
            if (done) begin
                state_d   = S_IDLE;
                armed_d   = 1'b0;
                rx_data_d = data_q;
                rx_wren_d = ~rx_full;
                ovr_d     = rx_full;
                perr_d    = par_err_q;
                ferr_d    = frm_err_q | ~bit_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            last_q    <= 3'd7;
            data_q    <= '0;
            rx_data_q <= '0;
            armed_q   <= 1'b0;
            stop2_q   <= 1'b0;
            par_q     <= PARITY_NONE;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            rx_wren_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            data_q    <= data_d;
            rx_data_q <= rx_data_d;
            armed_q   <= armed_d;
            stop2_q   <= stop2_d;
            par_q     <= par_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            rx_wren_q <= rx_wren_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end

    assign rx_data     = rx_data_q;
    assign rx_wren     = rx_wren_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;
    assign rx_busy     = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with hand-computed results for uart_rx
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0, sample_tick = 1'b0, rx = 1'b1, rx_full = 1'b0;
    logic [3:0] num_data_bits = 4'd8;
    stop_bits_t stop_bits = STOP_BITS_1;
    parity_t    parity = PARITY_NONE;
    logic [7:0] rx_data;
    logic       rx_wren, rx_busy, parity_err, frame_err, overrun_err;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx),
        .rx_data(rx_data), .rx_wren(rx_wren), .rx_full(rx_full), .rx_busy(rx_busy),
        .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
        .num_data_bits(num_data_bits), .stop_bits(stop_bits), .parity(parity)
    );

    always #5 clk = ~clk;

    int vec = 0, miss = 0;
    int ev = 0, wr = 0, ov = 0, e0 = 0, w0 = 0, o0 = 0;
    logic [7:0] last_data = 8'h00;
    logic [3:0] last_flags = 4'h0;

    // event log: {wren, overrun, parity, frame} of the most recent pulse clock
    always @(negedge clk)
        if (rx_wren | overrun_err | parity_err | frame_err) begin
            ev++;
            if (rx_wren) begin
                wr++;
                last_data = rx_data;
            end
            if (overrun_err) ov++;
            last_flags = {rx_wren, overrun_err, parity_err, frame_err};
        end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
    endtask

    task automatic send_bit(input logic v, input logic g);
        for (int t = 0; t < 16; t++) begin
            rx = (g && t == 7) ? ~v : v;
            tick();
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic frame(input logic [7:0] d, input int nb, input int pm, input logic pflip,
                         input logic s1, input logic s2, input int ns, input int gbit);
        logic p;
        p = 1'b0;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nb; i++) begin
            send_bit(d[i], i == gbit);
            p ^= d[i];
        end
        if (pm != 0) send_bit(((pm == 2) ? ~p : p) ^ pflip, 1'b0);
        send_bit(s1, 1'b0);
        if (ns == 2) send_bit(s2, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", 16'(rx_busy), 16'h0);
        chk("reset_data", 16'(rx_data), 16'h00);
        chk("reset_pulses", 16'({rx_wren, overrun_err, parity_err, frame_err}), 16'h0);
        rst_n = 1'b1;
        idle(4);

        e0 = ev;
        frame(8'hA5, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        chk("8n1_events", 16'(ev - e0), 16'd1);
        chk("8n1_flags", 16'(last_flags), 16'b1000);
        chk("8n1_data", 16'(last_data), 16'hA5);
        idle(8);
        chk("hold_data", 16'(rx_data), 16'hA5);
        chk("idle_busy", 16'(rx_busy), 16'h0);

        num_data_bits = 4'd7;
        parity = PARITY_EVEN;
        e0 = ev;
        frame(8'h35, 7, 1, 1'b1, 1'b1, 1'b1, 1, -1);
        chk("7e1_events", 16'(ev - e0), 16'd1);
        chk("7e1_flags", 16'(last_flags), 16'b1010);
        chk("7e1_data", 16'(last_data), 16'h35);

        num_data_bits = 4'd8;
        parity = PARITY_NONE;
        stop_bits = STOP_BITS_2;
        idle(4);
        frame(8'h3C, 8, 0, 1'b0, 1'b1, 1'b0, 2, -1);
        chk("8n2_flags", 16'(last_flags), 16'b1001);
        chk("8n2_data", 16'(last_data), 16'h3C);

        idle(4);
        e0 = ev;
        frame(8'h00, 8, 0, 1'b0, 1'b0, 1'b0, 2, -1);
        chk("break_flags", 16'(last_flags), 16'b1001);
        rx = 1'b0;
        repeat (40) tick();
        chk("break_busy", 16'(rx_busy), 16'h0);
        chk("break_events", 16'(ev - e0), 16'd1);
        stop_bits = STOP_BITS_1;
        idle(6);

        e0 = ev;
        rx = 1'b0;
        repeat (3) tick();
        chk("glitch_busy_hi", 16'(rx_busy), 16'h1);
        rx = 1'b1;
        repeat (8) tick();
        chk("glitch_busy_lo", 16'(rx_busy), 16'h0);
        chk("glitch_events", 16'(ev - e0), 16'd0);

        idle(4);
        e0 = ev; w0 = wr; o0 = ov;
        frame(8'h01, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        chk("b2b_first_data", 16'(last_data), 16'h01);
        rx_full = 1'b1;
        frame(8'hFF, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        chk("b2b_overrun_flags", 16'(last_flags), 16'b0100);
        chk("b2b_overrun_count", 16'(ov - o0), 16'd1);
        rx_full = 1'b0;
        frame(8'h55, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        chk("b2b_third_data", 16'(last_data), 16'h55);
        chk("b2b_writes", 16'(wr - w0), 16'd2);
        chk("b2b_events", 16'(ev - e0), 16'd3);

        idle(4);
        e0 = ev;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
        rx = 1'b0;
        repeat (5) tick();
        chk("rst_mid_busy", 16'(rx_busy), 16'h1);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        chk("rst_async_busy", 16'(rx_busy), 16'h0);
        rst_n = 1'b1;
        idle(20);
        chk("rst_no_events", 16'(ev - e0), 16'd0);
        frame(8'h5A, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        chk("rst_next_flags", 16'(last_flags), 16'b1000);
        chk("rst_next_data", 16'(last_data), 16'h5A);
`ifdef UART_RX_MAJORITY_EN
        idle(4);
        frame(8'h5A, 8, 0, 1'b0, 1'b1, 1'b1, 1, 3);
        chk("maj_glitch_data", 16'(last_data), 16'h5A);
`endif
        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
